// File: rtl/sonar_scan_sequencer.sv
// sonar_scan_sequencer: ping-pong servo sweep, timed measurement and 8-char ASCII frame output; optional re-measure on echo timeout via SCAN_RETRY_EN
module sonar_scan_sequencer #(
  parameter int DWELL        = 100_000_000,
  parameter int ECHO_TIMEOUT = 2_500_000,
  parameter int MAX_RETRY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        pronto_medida,
  input  logic [11:0] medida,
  input  logic        pronto_transmissao,
  output logic        medir,
  output logic        partida_serial,
  output logic [6:0]  dados_ascii,
  output logic [2:0]  posicao,
  output logic        fim_posicao,
  output logic        erro_medida,
  output logic [3:0]  db_estado
);
  localparam int DW = $clog2(DWELL + 1);
  localparam int TW = $clog2(ECHO_TIMEOUT + 1);
  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    POSICIONA = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    TRANSMITE = 4'd4,
    ESPERA_TX = 4'd5,
    PROXIMO   = 4'd6,
    AVANCA    = 4'd7
  } state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
  logic [11:0]   dist_q, dist_d;
  logic          medir_q, medir_d;
  logic          partida_q, partida_d;
  logic          fim_q, fim_d;
  logic          erro_q, erro_d;
  logic [6:0]    dados_q, dados_d;
  logic [3:0]    tens, dig;
  logic          bad;
  logic [6:0]    ch;
`ifdef SCAN_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif
  // character for the current frame index: angle digits, comma, distance digits (or '?'), '#'
  always_comb begin
    tens = pos_q[2] ? {1'b0, pos_q[1:0], 1'b0} : {1'b0, pos_q[1:0], 1'b0} + 4'd2;
    dig  = idx_q == 3'd0 ? {3'b0, pos_q[2]} :
           idx_q == 3'd1 ? tens :
           idx_q == 3'd4 ? dist_q[11:8] :
           idx_q == 3'd5 ? dist_q[7:4] :
           idx_q == 3'd6 ? dist_q[3:0] : 4'd0;
    bad  = (erro_q && idx_q[2] && idx_q != 3'd7) || dig > 4'd9;
    ch   = idx_q == 3'd3 ? 7'h2C :
           idx_q == 3'd7 ? 7'h23 :
           bad ? 7'h3F : 7'h30 + {3'b0, dig};
  end
  // next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    tout_d    = tout_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    dist_d    = dist_q;
    erro_d    = erro_q;
    dados_d   = dados_q;
    medir_d   = 1'b0;
    partida_d = 1'b0;
    fim_d     = 1'b0;
`ifdef SCAN_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      INICIAL: begin
        dwell_d = '0;
        idx_d   = '0;
        state_d = ligar ? POSICIONA : INICIAL;
      end
      POSICIONA: begin
        if (dwell_q == DW'(DWELL - 1)) state_d = MEDE;
        else dwell_d = dwell_q + 1'b1;
      end
      MEDE: begin
        medir_d = 1'b1;
        tout_d  = '0;
        state_d = AGUARDA;
      end
      AGUARDA: begin
        if (pronto_medida) begin
          dist_d  = medida;
          erro_d  = 1'b0;
          idx_d   = '0;
          state_d = TRANSMITE;
`ifdef SCAN_RETRY_EN
          retry_d = '0;
`endif
        end else if (tout_q == TW'(ECHO_TIMEOUT - 1)) begin
`ifdef SCAN_RETRY_EN
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = MEDE;
          end else begin
            erro_d  = 1'b1;
            idx_d   = '0;
            state_d = TRANSMITE;
          end
`else
          erro_d  = 1'b1;
          idx_d   = '0;
          state_d = TRANSMITE;
`endif
        end else tout_d = tout_q + 1'b1;
      end
      TRANSMITE: begin
        dados_d   = ch;
        partida_d = 1'b1;
        state_d   = ESPERA_TX;
      end
      ESPERA_TX: state_d = pronto_transmissao ? PROXIMO : ESPERA_TX;
      PROXIMO: begin
        if (idx_q == 3'd7) state_d = AVANCA;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = TRANSMITE;
        end
      end
      AVANCA: begin
        fim_d   = 1'b1;
        dwell_d = '0;
        dir_d   = dir_q ? pos_q != 3'd0 : pos_q == 3'd7;
        pos_d   = dir_q ? (pos_q == 3'd0 ? 3'd1 : pos_q - 1'b1) : (pos_q == 3'd7 ? 3'd6 : pos_q + 1'b1);
        state_d = ligar ? POSICIONA : INICIAL;
`ifdef SCAN_RETRY_EN
        retry_d = '0;
`endif
      end
      default: state_d = INICIAL;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INICIAL;
      dwell_q   <= '0;
      tout_q    <= '0;
      idx_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      dist_q    <= '0;
      medir_q   <= 1'b0;
      partida_q <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
      dados_q   <= '0;
`ifdef SCAN_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      tout_q    <= tout_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      dist_q    <= dist_d;
      medir_q   <= medir_d;
      partida_q <= partida_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
      dados_q   <= dados_d;
`ifdef SCAN_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end
  assign medir          = medir_q;
  assign partida_serial = partida_q;
  assign dados_ascii    = dados_q;
  assign posicao        = pos_q;
  assign fim_posicao    = fim_q;
  assign erro_medida    = erro_q;
  assign db_estado      = state_q;
endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// tb_sonar_scan_sequencer: scoreboard bench for the sonar scan sequencer
module tb_sonar_scan_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ligar = 1'b0;
  logic        pronto_medida = 1'b0;
  logic [11:0] medida = '0;
  logic        pronto_transmissao = 1'b0;
  logic        medir, partida_serial, fim_posicao, erro_medida;
  logic [6:0]  dados_ascii;
  logic [2:0]  posicao;
  logic [3:0]  db_estado;
  int total = 0;
  int bad = 0;
  int n_medir = 0;
  int m_skip = 0;
  int m_delay = 5;
  logic [11:0] m_val = 12'h123;
  logic [6:0] exp_ch[$];
  logic       exp_err[$];
  int         exp_pos[$];
  logic [23:0] ang [8] = '{"020", "040", "060", "080", "100", "120", "140", "160"};
  int seq [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  sonar_scan_sequencer #(.DWELL(10), .ECHO_TIMEOUT(20), .MAX_RETRY(2)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_medida(pronto_medida),
    .medida(medida), .pronto_transmissao(pronto_transmissao), .medir(medir),
    .partida_serial(partida_serial), .dados_ascii(dados_ascii), .posicao(posicao),
    .fim_posicao(fim_posicao), .erro_medida(erro_medida), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_frame(input logic [63:0] s, input logic err, input int nxt);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = s[63 - 8 * i -: 8];
      exp_ch.push_back(b[6:0]);
      exp_err.push_back(err);
    end
    exp_pos.push_back(nxt);
  endtask
  task automatic wait_fim(input int budget);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!fim_posicao && k < budget);
    if (!fim_posicao) check("fim_timeout", 0, 1);
  endtask
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (medir) n_medir++;
      if (partida_serial) begin
        if (exp_ch.size() == 0) check("unexpected_start", 1, 0);
        else begin
          check("char", dados_ascii, exp_ch.pop_front());
          check("erro_medida", erro_medida, exp_err.pop_front());
        end
      end
      if (fim_posicao) begin
        if (exp_pos.size() == 0) check("unexpected_fim", 1, 0);
        else check("posicao", posicao, exp_pos.pop_front());
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (medir && !reset) begin
      if (m_skip > 0) m_skip--;
      else begin
        repeat (m_delay) @(negedge clock);
        pronto_medida = 1'b1;
        medida = m_val;
        @(negedge clock);
        pronto_medida = 1'b0;
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (partida_serial && !reset) begin
      repeat (3) @(negedge clock);
      pronto_transmissao = 1'b1;
      @(negedge clock);
      pronto_transmissao = 1'b0;
    end
  end
  initial begin
    int base;
    int k;
    repeat (3) @(negedge clock);
    check("rst_state", db_estado, 0);
    check("rst_posicao", posicao, 0);
    check("rst_medir", medir, 0);
    check("rst_partida", partida_serial, 0);
    check("rst_fim", fim_posicao, 0);
    check("rst_erro", erro_medida, 0);
    check("rst_dados", dados_ascii, 0);
    reset = 1'b0;
    push_frame("020,123#", 1'b0, 1);
    ligar = 1'b1;
    wait_fim(400);
    for (int f = 1; f < 16; f++) begin
      push_frame({ang[seq[f]], ",123#"}, 1'b0, seq[f + 1]);
      wait_fim(400);
    end
    m_delay = 19;
    m_val = 12'h987;
    push_frame("060,987#", 1'b0, 3);
    base = n_medir;
    wait_fim(400);
    check("medir_at_expiry", n_medir - base, 1);
    m_delay = 5;
    m_val = 12'h1A0;
    push_frame("080,1?0#", 1'b0, 4);
    wait_fim(400);
    m_skip = 1000;
    base = n_medir;
`ifdef SCAN_RETRY_EN
    push_frame("100,???#", 1'b1, 5);
    wait_fim(600);
    check("medir_timeout", n_medir - base, 3);
    m_skip = 2;
    m_val = 12'h045;
    base = n_medir;
    push_frame("120,045#", 1'b0, 6);
    wait_fim(600);
    check("medir_retry", n_medir - base, 3);
`else
    push_frame("100,???#", 1'b1, 5);
    wait_fim(600);
    check("medir_timeout", n_medir - base, 1);
    m_skip = 2;
    m_val = 12'h045;
    base = n_medir;
    push_frame("120,???#", 1'b1, 6);
    wait_fim(600);
    check("medir_retry", n_medir - base, 1);
`endif
    m_skip = 0;
    m_val = 12'h123;
    push_frame("140,123#", 1'b0, 7);
    k = 0;
    while (exp_ch.size() > 4 && k < 300) begin
      @(negedge clock);
      k++;
    end
    check("reach_char3", exp_ch.size() <= 4, 1);
    ligar = 1'b0;
    wait_fim(400);
    repeat (3) @(negedge clock);
    check("idle_state", db_estado, 0);
    check("idle_posicao", posicao, 7);
    base = n_medir;
    repeat (30) @(negedge clock);
    check("idle_no_medir", n_medir - base, 0);
    check("idle_still", db_estado, 0);
    check("queue_drained", exp_ch.size(), 0);
    push_frame("160,123#", 1'b0, 6);
    ligar = 1'b1;
    k = 0;
    while (db_estado != 4'd5 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("reach_espera_tx", db_estado, 5);
    reset = 1'b1;
    ligar = 1'b0;
    @(negedge clock);
    check("mid_rst_state", db_estado, 0);
    check("mid_rst_posicao", posicao, 0);
    check("mid_rst_medir", medir, 0);
    check("mid_rst_partida", partida_serial, 0);
    check("mid_rst_fim", fim_posicao, 0);
    check("mid_rst_erro", erro_medida, 0);
    exp_ch.delete();
    exp_err.delete();
    exp_pos.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("post_rst_state", db_estado, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
